// File: rtl/adc_cmd_sequencer.sv
// ADS1256 command sequencer sitting directly in front of spi_top.
// After a host start it runs the init sequence (SDATAC, optionally SELFCAL and
// a calibration DRDY wait), then issues one RDATA per DRDY_L falling edge until
// the requested sample count is reached, a stop arrives, or DRDY times out.
// Optional feature macro: ADC_SEQ_SELFCAL_EN (adds SELFCAL + calibration DRDY wait).

package adc_cmd_sequencer_pkg;

  // Transaction selector handed to spi_top.
  typedef enum logic [1:0] {
    CMD_NONE    = 2'd0,
    CMD_SDATAC  = 2'd1,
    CMD_SELFCAL = 2'd2,
    CMD_RDATA   = 2'd3
  } transaction_t;

endpackage

module adc_cmd_sequencer
  import adc_cmd_sequencer_pkg::*;
#(
  parameter int unsigned DRDY_TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned SAMPLE_CNT_W        = 16
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    DRDY_L_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic [SAMPLE_CNT_W-1:0] num_samples_i,
  output logic                    transaction_start_o,
  output transaction_t            transaction_o,
  input  logic                    transaction_done_i,
  output logic                    busy_o,
  output logic [SAMPLE_CNT_W-1:0] sample_count_o,
  output logic                    timeout_o
);

  // Timeout counter only has to reach DRDY_TIMEOUT_CYCLES-1.
  localparam int unsigned TmoW =
      (DRDY_TIMEOUT_CYCLES > 2) ? $clog2(DRDY_TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(DRDY_TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    StIdle,
    StIssueSdatac,
    StWaitSdatac,
`ifdef ADC_SEQ_SELFCAL_EN
    StIssueSelfcal,
    StWaitSelfcal,
    StWaitCalDrdy,
`endif
    StWaitDrdy,
    StIssueRdata,
    StWaitRdata,
    StDone,
    StError
  } state_e;

  state_e                  r_state;
  state_e                  w_state_next;

  logic                    r_drdy_meta;
  logic                    r_drdy_sync;
  logic                    r_drdy_hist;
  logic                    w_drdy_fall;

  logic [SAMPLE_CNT_W-1:0] r_num_samples;
  logic [SAMPLE_CNT_W-1:0] r_sample_cnt;
  logic [SAMPLE_CNT_W-1:0] w_cnt_inc;
  logic                    w_count_reached;
  logic                    r_timeout;
  logic                    r_stop_pending;
  logic                    w_stop_req;
  logic [TmoW-1:0]         r_tmo_cnt;
  logic                    w_tmo_hit;

  logic                    w_idle_like;
  logic                    w_in_cmd;
  logic                    w_drdy_wait;
  logic                    w_accept;

  // Bring DRDY_L into the clock domain and keep one history bit for edge detect.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_drdy_meta <= 1'b1;
      r_drdy_sync <= 1'b1;
      r_drdy_hist <= 1'b1;
    end else begin
      r_drdy_meta <= DRDY_L_i;
      r_drdy_sync <= r_drdy_meta;
      r_drdy_hist <= r_drdy_sync;
    end
  end

  assign w_drdy_fall = r_drdy_hist & ~r_drdy_sync;

  // Decode state classes used by both the FSM and the datapath.
  always_comb begin
    w_idle_like = 1'b0;
    w_in_cmd    = 1'b0;
    w_drdy_wait = 1'b0;
    unique case (r_state)
      StIdle, StDone, StError: w_idle_like = 1'b1;
      StIssueSdatac, StWaitSdatac, StIssueRdata, StWaitRdata: w_in_cmd = 1'b1;
`ifdef ADC_SEQ_SELFCAL_EN
      StIssueSelfcal, StWaitSelfcal: w_in_cmd = 1'b1;
      StWaitCalDrdy: w_drdy_wait = 1'b1;
`endif
      StWaitDrdy: w_drdy_wait = 1'b1;
      default: ;
    endcase
  end

  assign w_accept   = w_idle_like & start_i;
  // A stop arriving in the same cycle as done still ends the run after that done.
  assign w_stop_req = r_stop_pending | stop_i;
  assign w_tmo_hit  = (r_tmo_cnt == TmoLast);
  assign w_cnt_inc  = (r_sample_cnt == '1) ? r_sample_cnt : r_sample_cnt + 1'b1;
  assign w_count_reached = (r_num_samples != '0) && (w_cnt_inc == r_num_samples);

  // FSM state register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StDone, StError: begin
        if (start_i) w_state_next = StIssueSdatac;
      end
      StIssueSdatac: w_state_next = StWaitSdatac;
      StWaitSdatac: begin
        if (transaction_done_i) begin
          if (w_stop_req) begin
            w_state_next = StDone;
          end else begin
`ifdef ADC_SEQ_SELFCAL_EN
            w_state_next = StIssueSelfcal;
`else
            w_state_next = StWaitDrdy;
`endif
          end
        end
      end
`ifdef ADC_SEQ_SELFCAL_EN
      StIssueSelfcal: w_state_next = StWaitSelfcal;
      StWaitSelfcal: begin
        if (transaction_done_i) begin
          w_state_next = w_stop_req ? StDone : StWaitCalDrdy;
        end
      end
      StWaitCalDrdy: begin
        // Stop beats a same-cycle edge; an edge beats a same-cycle timeout.
        if (stop_i) begin
          w_state_next = StDone;
        end else if (w_drdy_fall) begin
          w_state_next = StWaitDrdy;
        end else if (w_tmo_hit) begin
          w_state_next = StError;
        end
      end
`endif
      StWaitDrdy: begin
        if (stop_i) begin
          w_state_next = StDone;
        end else if (w_drdy_fall) begin
          w_state_next = StIssueRdata;
        end else if (w_tmo_hit) begin
          w_state_next = StError;
        end
      end
      StIssueRdata: w_state_next = StWaitRdata;
      StWaitRdata: begin
        // DRDY edges seen here are overruns and are intentionally dropped.
        if (transaction_done_i) begin
          w_state_next = (w_stop_req || w_count_reached) ? StDone : StWaitDrdy;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs: start pulse, held command and busy flag.
  always_comb begin
    transaction_start_o = 1'b0;
    transaction_o       = CMD_NONE;
    busy_o              = 1'b1;
    unique case (r_state)
      StIdle, StDone, StError: busy_o = 1'b0;
      StIssueSdatac: begin
        transaction_start_o = 1'b1;
        transaction_o       = CMD_SDATAC;
      end
      StWaitSdatac: transaction_o = CMD_SDATAC;
`ifdef ADC_SEQ_SELFCAL_EN
      StIssueSelfcal: begin
        transaction_start_o = 1'b1;
        transaction_o       = CMD_SELFCAL;
      end
      StWaitSelfcal: transaction_o = CMD_SELFCAL;
`endif
      StIssueRdata: begin
        transaction_start_o = 1'b1;
        transaction_o       = CMD_RDATA;
      end
      StWaitRdata: transaction_o = CMD_RDATA;
      default: ;
    endcase
  end

  // Run bookkeeping: latched request, sample count, stop/timeout flags.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_num_samples  <= '0;
      r_sample_cnt   <= '0;
      r_timeout      <= 1'b0;
      r_stop_pending <= 1'b0;
    end else if (w_accept) begin
      r_num_samples  <= num_samples_i;
      r_sample_cnt   <= '0;
      r_timeout      <= 1'b0;
      r_stop_pending <= 1'b0;
    end else begin
      if (w_in_cmd && stop_i) begin
        r_stop_pending <= 1'b1;
      end
      if (r_state == StWaitRdata && transaction_done_i) begin
        r_sample_cnt <= w_cnt_inc;
      end
      if (w_drdy_wait && w_state_next == StError) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // DRDY wait timer: zero on every state change, counts while waiting.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_tmo_cnt <= '0;
    end else if (w_state_next != r_state) begin
      r_tmo_cnt <= '0;
    end else if (w_drdy_wait) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign sample_count_o = r_sample_cnt;
  assign timeout_o      = r_timeout;

endmodule

// File: tb/tb_adc_cmd_sequencer.sv
// Scoreboard bench for adc_cmd_sequencer: stimulus pushes the expected command
// stream, a monitor pops and compares on every transaction_start_o pulse.
// Behaves correctly with or without ADC_SEQ_SELFCAL_EN defined.
module tb_adc_cmd_sequencer;
  import adc_cmd_sequencer_pkg::*;

  localparam int unsigned TmoCycles = 100;

  logic         clock_i            = 1'b0;
  logic         reset_i            = 1'b0;
  logic         DRDY_L_i           = 1'b1;
  logic         start_i            = 1'b0;
  logic         stop_i             = 1'b0;
  logic [15:0]  num_samples_i      = '0;
  logic         transaction_done_i = 1'b0;
  logic         transaction_start_o;
  transaction_t transaction_o;
  logic         busy_o;
  logic [15:0]  sample_count_o;
  logic         timeout_o;

  int n_checks = 0;
  int n_errors = 0;
  transaction_t exp_q[$];
  int cyc = 0;
  int n_starts = 0;
  int n_rdata_starts = 0;
  int last_done_cyc = 0;
  int spi_lat = 10;
  bit drdy_run = 1'b0;
  int drdy_req = 0;
  int drdy_ack = 0;

  adc_cmd_sequencer #(
    .DRDY_TIMEOUT_CYCLES(TmoCycles),
    .SAMPLE_CNT_W       (16)
  ) dut (
    .clock_i            (clock_i),
    .reset_i            (reset_i),
    .DRDY_L_i           (DRDY_L_i),
    .start_i            (start_i),
    .stop_i             (stop_i),
    .num_samples_i      (num_samples_i),
    .transaction_start_o(transaction_start_o),
    .transaction_o      (transaction_o),
    .transaction_done_i (transaction_done_i),
    .busy_o             (busy_o),
    .sample_count_o     (sample_count_o),
    .timeout_o          (timeout_o)
  );

  initial forever #5 clock_i = ~clock_i;

  initial forever begin
    @(posedge clock_i);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every start pulse consumes one expected command.
  initial begin : monitor
    transaction_t e;
    forever begin
      @(negedge clock_i);
      if (!reset_i && transaction_start_o) begin
        n_starts++;
        if (transaction_o == CMD_RDATA) n_rdata_starts++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_start: got cmd %0d, expected no transaction",
                   int'(transaction_o));
        end else begin
          e = exp_q.pop_front();
          check("txn_cmd", int'(transaction_o), int'(e));
        end
      end
    end
  end

  // spi_top stand-in: done strobe spi_lat cycles after each start, aborted by reset.
  initial begin : spi_model
    bit aborted;
    forever begin
      if (transaction_start_o && !reset_i) begin
        aborted = 1'b0;
        for (int i = 0; i < spi_lat; i++) begin
          @(negedge clock_i);
          if (reset_i) aborted = 1'b1;
          if (aborted) break;
        end
        if (!aborted) begin
          transaction_done_i = 1'b1;
          @(negedge clock_i);
          transaction_done_i = 1'b0;
          last_done_cyc = cyc;
        end
      end else begin
        @(negedge clock_i);
      end
    end
  end

  // DRDY_L source: free-running (40-cycle period) or single requested pulses.
  initial begin : drdy_gen
    forever begin
      if (drdy_req != drdy_ack || drdy_run) begin
        if (drdy_req != drdy_ack) drdy_ack++;
        DRDY_L_i = 1'b0;
        repeat (4) @(negedge clock_i);
        DRDY_L_i = 1'b1;
        repeat (16) @(negedge clock_i);
        if (drdy_run) repeat (20) @(negedge clock_i);
      end else begin
        @(negedge clock_i);
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock_i);
  endtask

  task automatic push_init();
    exp_q.push_back(CMD_SDATAC);
`ifdef ADC_SEQ_SELFCAL_EN
    exp_q.push_back(CMD_SELFCAL);
`endif
  endtask

  task automatic push_rdata(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(CMD_RDATA);
  endtask

  task automatic do_start(input int n, input bit with_stop);
    num_samples_i = 16'(n);
    start_i       = 1'b1;
    stop_i        = with_stop;
    @(negedge clock_i);
    start_i = 1'b0;
    stop_i  = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int k = 0;
    while (busy_o && k < max) begin
      @(negedge clock_i);
      k++;
    end
    check({name, "_idle_reached"}, int'(busy_o), 0);
  endtask

  task automatic wait_rdata(input string name, input int target, input int max);
    int k = 0;
    while (n_rdata_starts < target && k < max) begin
      @(negedge clock_i);
      k++;
    end
    check({name, "_rdata_reached"}, n_rdata_starts, target);
  endtask

  initial begin : main
    int base;
    int k;
    int s;

    // Reset values, applied asynchronously.
    #2 reset_i = 1'b1;
    #1;
    check("rst_start", int'(transaction_start_o), 0);
    check("rst_txn", int'(transaction_o), int'(CMD_NONE));
    check("rst_busy", int'(busy_o), 0);
    check("rst_count", int'(sample_count_o), 0);
    check("rst_timeout", int'(timeout_o), 0);
    tick(3);
    reset_i = 1'b0;
    tick(2);

    // Nominal: N=3.
    drdy_run = 1'b1;
    push_init();
    push_rdata(3);
    do_start(3, 1'b0);
    wait_idle("nominal", 2000);
    check("nominal_count", int'(sample_count_o), 3);
    check("nominal_busy", int'(busy_o), 0);
    check("nominal_timeout", int'(timeout_o), 0);
    tick(100);
    check("nominal_q_empty", exp_q.size(), 0);

    // Unlimited run, stop during the 5th RDATA.
    base = n_rdata_starts;
    push_init();
    push_rdata(5);
    do_start(0, 1'b0);
    wait_rdata("stop5", base + 5, 3000);
    tick(2);
    stop_i = 1'b1;
    tick(1);
    stop_i = 1'b0;
    wait_idle("stop5", 200);
    check("stop5_count", int'(sample_count_o), 5);
    tick(100);
    check("stop5_no_sixth", n_rdata_starts - base, 5);
    check("stop5_q_empty", exp_q.size(), 0);

    // DRDY timeout: no edges after init.
    drdy_run = 1'b0;
    tick(50);
    push_init();
    do_start(1, 1'b0);
    k = 0;
    while (!timeout_o && k < 1000) begin
      @(negedge clock_i);
      k++;
    end
    check("tmo_set", int'(timeout_o), 1);
    check("tmo_latency", cyc - last_done_cyc, 100);
    check("tmo_busy", int'(busy_o), 0);
    check("tmo_count", int'(sample_count_o), 0);
    check("tmo_q_empty", exp_q.size(), 0);
    // Restart clears timeout; stop during SDATAC ends the run after it.
    exp_q.push_back(CMD_SDATAC);
    do_start(1, 1'b0);
    check("tmo_cleared", int'(timeout_o), 0);
    stop_i = 1'b1;
    tick(1);
    stop_i = 1'b0;
    wait_idle("stop_sdatac", 200);
    check("stop_sdatac_timeout", int'(timeout_o), 0);
    check("stop_sdatac_count", int'(sample_count_o), 0);
    tick(20);
    check("stop_sdatac_q_empty", exp_q.size(), 0);

    // Overrun: a DRDY edge during WAIT_RDATA must not queue another RDATA.
    spi_lat = 60;
    base = n_rdata_starts;
    push_init();
    push_rdata(2);
    do_start(2, 1'b0);
    for (k = 0; k < 2000; k++) begin
      if (k % 40 == 0) drdy_req++;
      tick(1);
      if (n_rdata_starts == base + 1) break;
    end
    check("ovr_first_rdata", n_rdata_starts - base, 1);
    drdy_req++;
    k = 0;
    while (sample_count_o != 16'd1 && k < 300) begin
      @(negedge clock_i);
      k++;
    end
    check("ovr_count1", int'(sample_count_o), 1);
    tick(50);
    check("ovr_not_queued", n_rdata_starts - base, 1);
    drdy_req++;
    wait_idle("ovr", 500);
    check("ovr_count2", int'(sample_count_o), 2);
    check("ovr_q_empty", exp_q.size(), 0);

    // Reset during WAIT_RDATA.
    spi_lat = 30;
    drdy_run = 1'b1;
    base = n_rdata_starts;
    push_init();
    push_rdata(1);
    do_start(0, 1'b0);
    wait_rdata("rst", base + 1, 2000);
    tick(5);
    #2 reset_i = 1'b1;
    #1;
    check("midrst_start", int'(transaction_start_o), 0);
    check("midrst_txn", int'(transaction_o), int'(CMD_NONE));
    check("midrst_busy", int'(busy_o), 0);
    check("midrst_count", int'(sample_count_o), 0);
    tick(3);
    reset_i = 1'b0;
    s = n_starts;
    tick(200);
    check("midrst_no_start", n_starts - s, 0);
    check("midrst_q_empty", exp_q.size(), 0);

    // N=1 with stop in the same cycle as start: start wins.
    spi_lat = 10;
    push_init();
    push_rdata(1);
    do_start(1, 1'b1);
    wait_idle("n1", 1000);
    check("n1_count", int'(sample_count_o), 1);
    check("n1_timeout", int'(timeout_o), 0);
    tick(50);
    check("n1_q_empty", exp_q.size(), 0);

    drdy_run = 1'b0;
    tick(5);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_cmd_sequencer.md
Name: adc_cmd_sequencer

Overview:
- Command sequencer directly upstream of spi_top. It decides which ADS1256 transaction spi_top runs next, and when.
- On a host start it runs the init sequence: SDATAC, then SELFCAL (optional feature), then waits for calibration DRDY.
- It then issues one RDATA per DRDY_L falling edge until the requested sample count is reached, a stop arrives, or a DRDY timeout fires.
- Drives spi_top's transaction_start_i / transaction_i and consumes transaction_done_o.

Parameters:
- DRDY_TIMEOUT_CYCLES, 50_000_000: max clock cycles spent waiting for a DRDY_L falling edge before flagging a timeout.
- SAMPLE_CNT_W, 16: width of the sample-count request and the sample counter.

Ports:
- clock_i  in  1  system clock (100 MHz nominal).
- reset_i  in  1  asynchronous, active-high reset.
- DRDY_L_i  in  1  ADC data-ready, active low, asynchronous to clock_i.
- start_i  in  1  one-cycle pulse; begin acquisition. Ignored unless in IDLE/DONE/ERROR.
- stop_i  in  1  one-cycle pulse; end acquisition after any in-flight transaction.
- num_samples_i  in  SAMPLE_CNT_W  samples to take; sampled on start_i; 0 = unlimited until stop_i.
- transaction_start_o  out  1  one-cycle pulse to spi_top.
- transaction_o  out  transaction_t  command to spi_top; held stable from the start pulse until done.
- transaction_done_i  in  1  spi_top completion strobe.
- busy_o  out  1  high in every state except IDLE/DONE/ERROR.
- sample_count_o  out  SAMPLE_CNT_W  completed RDATA transactions since the last start.
- timeout_o  out  1  sticky; set on DRDY timeout, cleared by the next accepted start_i.

Behaviour:
- Reset values: transaction_start_o=0, transaction_o=CMD_NONE, busy_o=0, sample_count_o=0, timeout_o=0, state=IDLE.
- DRDY_L_i passes through a 2-flop synchronizer plus one history flop, reset to 1. A falling edge (drdy_fall) is detected 3 clocks after the pin falls.
- States:
  - IDLE/DONE/ERROR: start_i → ISSUE_SDATAC. On accept, latch num_samples_i, clear sample_count_o and timeout_o.
  - ISSUE_x: pulse transaction_start_o for one cycle with transaction_o=x, then → WAIT_x.
  - WAIT_SDATAC: on transaction_done_i → ISSUE_SELFCAL (feature on) or WAIT_DRDY (feature off).
  - WAIT_SELFCAL: on transaction_done_i → WAIT_CAL_DRDY.
  - WAIT_CAL_DRDY: on drdy_fall → WAIT_DRDY. Timeout applies here.
  - WAIT_DRDY: on drdy_fall → ISSUE_RDATA. Timeout applies here.
  - WAIT_RDATA: on transaction_done_i, sample_count_o+1, then:
    - if stop_pending, or (latched N≠0 and new count==N) → DONE;
    - else → WAIT_DRDY.
- Handshake rules:
  - Never pulse transaction_start_o while waiting for done.
  - transaction_done_i outside a WAIT_<cmd> state is ignored.
  - transaction_o returns to CMD_NONE in the cycle after done.
- Timeout:
  - Counter is cleared on entry to each DRDY wait and increments each cycle.
  - When it reaches DRDY_TIMEOUT_CYCLES-1 without drdy_fall: timeout_o=1 → ERROR.
  - drdy_fall on that same cycle wins: no timeout.
- stop_i:
  - In a DRDY wait state: → DONE next cycle.
  - In ISSUE/WAIT states: set stop_pending. The current transaction completes (RDATA still counted), then → DONE.
  - In IDLE/DONE/ERROR: ignored.
  - start_i and stop_i in the same cycle from IDLE: start wins, stop is dropped.
- A drdy_fall during WAIT_RDATA (ADC overrun) is dropped; no queuing.
- sample_count_o saturates at all-ones.
- Reset mid-transaction returns to IDLE immediately. spi_top shares reset_i.

Optional Feature:
- Macro ADC_SEQ_SELFCAL_EN.
- Defined: init sequence is SDATAC → SELFCAL → wait calibration DRDY → acquisition.
- Undefined: SELFCAL and WAIT_CAL_DRDY states are not compiled. After SDATAC done → WAIT_DRDY directly.

Test Plan:
- Nominal, feature on: start_i with num_samples_i=3; DRDY_L falls every 3000 ns. Expect transaction sequence SDATAC, SELFCAL, RDATA×3. First RDATA only after the second DRDY fall. sample_count_o=3, busy_o=0 in DONE, timeout_o=0.
- Unlimited + stop: num_samples_i=0; pulse stop_i mid-RDATA on the 5th transaction. RDATA completes, sample_count_o=5, then DONE; no 6th transaction_start_o.
- Timeout: DRDY_TIMEOUT_CYCLES=100; hold DRDY_L high after SDATAC. Expect timeout_o=1 and ERROR exactly 100 cycles after entering WAIT_DRDY. A following start_i clears timeout_o.
- Overrun: drive a DRDY fall while WAIT_RDATA is active. Only one RDATA is issued per done; count increments by 1.
- Reset: assert reset_i during WAIT_RDATA. Outputs reach reset values asynchronously; no transaction_start_o until a new start_i.
- Feature off (ADC_SEQ_SELFCAL_EN undefined), num_samples_i=1. Sequence is exactly SDATAC then RDATA; no SELFCAL.
